// File: rtl/rgb_merger.sv
// rgb_merger
//   Merges three separately delivered channel samples into one RGB pixel.
//   Values pass through unchanged; the block only aligns the three channels
//   and a qualifying valid bit through a LATENCY-deep register pipeline.
//
//   Pipeline behaviour:
//     - Stage 0 captures r_in/g_in/b_in on a rising edge where data_valid=1.
//     - Each later stage copies its predecessor only when the predecessor
//       holds a valid pixel, so the last stage (the outputs) keeps the most
//       recent valid pixel while data_out_valid is low.
//     - A pixel captured on edge N is presented after edge N+LATENCY-1.
//     - One pixel per clock, no backpressure.
//
// Parameters
//   DATA_WIDTH  per-channel sample width in bits (default 8)
//   LATENCY     number of register stages, legal range 1..4 (default 1)
//
// Ports
//   clk             in   1           rising-edge clock
//   rst_n           in   1           asynchronous active-low reset; clears
//                                    every stage, including in-flight pixels
//   r_in            in   DATA_WIDTH  red sample
//   g_in            in   DATA_WIDTH  green sample
//   b_in            in   DATA_WIDTH  blue sample
//   data_valid      in   1           qualifies r_in/g_in/b_in this edge
//   r_out           out  DATA_WIDTH  merged pixel, red
//   g_out           out  DATA_WIDTH  merged pixel, green
//   b_out           out  DATA_WIDTH  merged pixel, blue
//   data_out_valid  out  1           one-cycle pulse per merged pixel
module rgb_merger #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LATENCY    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] r_in,
   input  logic [DATA_WIDTH-1:0] g_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   input  logic                  data_valid,
   output logic [DATA_WIDTH-1:0] r_out,
   output logic [DATA_WIDTH-1:0] g_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  data_out_valid
);

   // Per-stage storage; index 0 is the capture stage, LATENCY-1 drives the outputs.
   logic [DATA_WIDTH-1:0] r_stage [LATENCY];
   logic [DATA_WIDTH-1:0] g_stage [LATENCY];
   logic [DATA_WIDTH-1:0] b_stage [LATENCY];
   logic [LATENCY-1:0]    vld_stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_stage <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_stage[i] <= '0;
            g_stage[i] <= '0;
            b_stage[i] <= '0;
         end
      end else begin
         // Capture stage: input values are ignored unless qualified.
         vld_stage[0] <= data_valid;
         if (data_valid) begin
            r_stage[0] <= r_in;
            g_stage[0] <= g_in;
            b_stage[0] <= b_in;
         end
         // Data in a stage moves only with a set valid bit, so every stage
         // (and hence the outputs) holds its last valid pixel between pulses.
         for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_stage[i] <= vld_stage[i-1];
            if (vld_stage[i-1]) begin
               r_stage[i] <= r_stage[i-1];
               g_stage[i] <= g_stage[i-1];
               b_stage[i] <= b_stage[i-1];
            end
         end
      end
   end

   assign r_out          = r_stage[LATENCY-1];
   assign g_out          = g_stage[LATENCY-1];
   assign b_out          = b_stage[LATENCY-1];
   assign data_out_valid = vld_stage[LATENCY-1];

endmodule

// File: tb/tb_rgb_merger.sv
// tb_rgb_merger
//   Directed bench for rgb_merger. Two instances share the stimulus: one at
//   LATENCY=1 and one at LATENCY=3. Expected values are written out by hand;
//   the LATENCY=3 instance shows each pixel two edges after the LATENCY=1 one.
module tb_rgb_merger;

   logic       clk;
   logic       rst_n;
   logic [7:0] r_in, g_in, b_in;
   logic       data_valid;

   logic [7:0] r1, g1, b1;
   logic       v1;
   logic [7:0] r3, g3, b3;
   logic       v3;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   rgb_merger #(.DATA_WIDTH(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .data_valid(data_valid),
      .r_out(r1), .g_out(g1), .b_out(b1), .data_out_valid(v1)
   );

   rgb_merger #(.DATA_WIDTH(8), .LATENCY(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .data_valid(data_valid),
      .r_out(r3), .g_out(g3), .b_out(b3), .data_out_valid(v3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pix(input logic v, input logic [7:0] r,
                                       input logic [7:0] g, input logic [7:0] b);
      return {7'd0, v, r, g, b};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      data_valid = v;
      r_in       = r;
      g_in       = g;
      b_in       = b;
   endtask

   function automatic logic [31:0] o1();
      return pix(v1, r1, g1, b1);
   endfunction

   function automatic logic [31:0] o3();
      return pix(v3, r3, g3, b3);
   endfunction

   initial begin
      logic [7:0] re, ge, be;

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      #12;
      check_eq("reset_l1", o1(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      check_eq("reset_l3", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_eq("post_reset_idle_l1", o1(), pix(1'b0, 8'd0, 8'd0, 8'd0));

      // Single pixel 255/128/64
      drive(1'b1, 8'd255, 8'd128, 8'd64);
      tick();
      check_eq("single_l1_valid", o1(), pix(1'b1, 8'd255, 8'd128, 8'd64));
      check_eq("single_l3_stage0", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      tick();
      check_eq("single_l1_hold", o1(), pix(1'b0, 8'd255, 8'd128, 8'd64));
      check_eq("single_l3_stage1", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      tick();
      check_eq("single_l3_valid", o3(), pix(1'b1, 8'd255, 8'd128, 8'd64));
      tick();
      check_eq("single_l3_hold", o3(), pix(1'b0, 8'd255, 8'd128, 8'd64));

      // Separated single pixels
      drive(1'b1, 8'd100, 8'd200, 8'd50);
      tick();
      check_eq("seq_a_valid", o1(), pix(1'b1, 8'd100, 8'd200, 8'd50));
      drive(1'b0, 8'd1, 8'd2, 8'd3);
      tick();
      check_eq("seq_a_hold1", o1(), pix(1'b0, 8'd100, 8'd200, 8'd50));
      tick();
      check_eq("seq_a_hold2", o1(), pix(1'b0, 8'd100, 8'd200, 8'd50));
      check_eq("seq_a_l3", o3(), pix(1'b1, 8'd100, 8'd200, 8'd50));
      drive(1'b1, 8'd0, 8'd255, 8'd128);
      tick();
      check_eq("seq_b_valid", o1(), pix(1'b1, 8'd0, 8'd255, 8'd128));
      check_eq("seq_b_l3_hold", o3(), pix(1'b0, 8'd100, 8'd200, 8'd50));
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      tick();
      check_eq("seq_b_hold", o1(), pix(1'b0, 8'd0, 8'd255, 8'd128));
      tick();
      check_eq("seq_b_l3", o3(), pix(1'b1, 8'd0, 8'd255, 8'd128));
      tick();

      // Back-to-back ramp of 16 pixels
      for (int i = 0; i < 16; i++) begin
         re = 8'(i);
         ge = 8'(255 - i);
         be = 8'(2 * i);
         drive(1'b1, re, ge, be);
         tick();
         check_eq($sformatf("ramp_l1_%0d", i), o1(), pix(1'b1, re, ge, be));
         if (i >= 2)
            check_eq($sformatf("ramp_l3_%0d", i - 2), o3(),
                     pix(1'b1, 8'(i - 2), 8'(257 - i), 8'(2 * i - 4)));
         else
            check_eq($sformatf("ramp_l3_fill_%0d", i), o3(), pix(1'b0, 8'd0, 8'd255, 8'd128));
      end
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      tick();
      check_eq("ramp_l1_end", o1(), pix(1'b0, 8'd15, 8'd240, 8'd30));
      check_eq("ramp_l3_14", o3(), pix(1'b1, 8'd14, 8'd241, 8'd28));
      tick();
      check_eq("ramp_l3_15", o3(), pix(1'b1, 8'd15, 8'd240, 8'd30));
      tick();
      check_eq("ramp_l3_end", o3(), pix(1'b0, 8'd15, 8'd240, 8'd30));

      // Idle with toggling inputs
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
         tick();
         check_eq($sformatf("idle_l1_%0d", i), o1(), pix(1'b0, 8'd15, 8'd240, 8'd30));
         check_eq($sformatf("idle_l3_%0d", i), o3(), pix(1'b0, 8'd15, 8'd240, 8'd30));
      end

      // Reset mid-stream with a pixel in flight in the LATENCY=3 instance
      drive(1'b1, 8'd9, 8'd8, 8'd7);
      tick();
      check_eq("inflight_l1", o1(), pix(1'b1, 8'd9, 8'd8, 8'd7));
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_reset_l1", o1(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      check_eq("async_reset_l3", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq($sformatf("no_stale_l1_%0d", i), o1(), pix(1'b0, 8'd0, 8'd0, 8'd0));
         check_eq($sformatf("no_stale_l3_%0d", i), o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      end

      // First pixel after reset, LATENCY=3 timing with 17/34/51
      drive(1'b1, 8'd17, 8'd34, 8'd51);
      tick();
      check_eq("l3_pix_l1", o1(), pix(1'b1, 8'd17, 8'd34, 8'd51));
      check_eq("l3_pix_e0", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      tick();
      check_eq("l3_pix_e1", o3(), pix(1'b0, 8'd0, 8'd0, 8'd0));
      tick();
      check_eq("l3_pix_e2", o3(), pix(1'b1, 8'd17, 8'd34, 8'd51));
      tick();
      check_eq("l3_pix_e3", o3(), pix(1'b0, 8'd17, 8'd34, 8'd51));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
